// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one single-ported memory between fetch and data
// ports, one read in flight, with data priority bounded by a starvation limit.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   input  logic        if_kill_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_gnt_o,
   output logic        dm_rvalid_o,
   output logic [31:0] dm_rdata_o,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   localparam logic       c_own_if     = 1'b0;
   localparam logic       c_own_dm     = 1'b1;
   localparam logic [2:0] c_mem_lat    = 3'(MEM_LAT);
   localparam logic [2:0] c_starve_max = 3'(STARVE_MAX);

   state_t     r_state, w_state_nxt;
   logic       r_owner, w_owner_nxt;
   logic [2:0] r_lat_cnt, w_lat_nxt;
   logic [2:0] r_starve_cnt, w_starve_nxt;
   logic       r_kill, w_kill_nxt;

   logic w_port_free, w_ret, w_if_req, w_if_pri, w_gnt_read;

   assign if_rdata_o = mem_rdata_i;
   assign dm_rdata_o = mem_rdata_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_owner      <= c_own_if;
         r_lat_cnt    <= 3'd0;
         r_starve_cnt <= 3'd0;
         r_kill       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_lat_cnt    <= w_lat_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_kill       <= w_kill_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_lat_nxt    = r_lat_cnt;
      w_starve_nxt = r_starve_cnt;
      w_kill_nxt   = r_kill;
      if_gnt_o     = 1'b0;
      dm_gnt_o     = 1'b0;
      if_rvalid_o  = 1'b0;
      dm_rvalid_o  = 1'b0;
      mem_en_o     = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = 32'd0;
      mem_wdata_o  = 32'd0;

      w_ret       = (r_state == S_BUSY) && (r_lat_cnt == 3'd1);
      w_port_free = (r_state == S_IDLE) || w_ret;
      // A killed cycle never grants a fetch, so it also forfeits fetch priority
      w_if_req    = if_req_i && !if_kill_i;
      w_if_pri    = w_if_req && (r_starve_cnt == c_starve_max);

      if (!rst_i) begin
         if (w_port_free) begin
            if (w_if_pri || (w_if_req && !dm_req_i)) begin
               if_gnt_o   = 1'b1;
               mem_en_o   = 1'b1;
               mem_addr_o = if_addr_i;
            end else if (dm_req_i) begin
               dm_gnt_o    = 1'b1;
               mem_en_o    = 1'b1;
               mem_we_o    = dm_we_i;
               mem_addr_o  = dm_addr_i;
               mem_wdata_o = dm_wdata_i;
            end
         end
         if (w_ret) begin
            if (r_owner == c_own_if)
               if_rvalid_o = !r_kill && !if_kill_i;
            else
               dm_rvalid_o = 1'b1;
         end
      end

      w_gnt_read = if_gnt_o || (dm_gnt_o && !dm_we_i);

      if (w_gnt_read) begin
         w_state_nxt = S_BUSY;
         w_lat_nxt   = c_mem_lat;
         w_owner_nxt = if_gnt_o ? c_own_if : c_own_dm;
         w_kill_nxt  = 1'b0;
      end else if (r_state == S_BUSY) begin
         w_lat_nxt = r_lat_cnt - 3'd1;
         if (w_ret) begin
            w_state_nxt = S_IDLE;
            w_kill_nxt  = 1'b0;
         end else if ((r_owner == c_own_if) && if_kill_i) begin
            w_kill_nxt = 1'b1;
         end
      end

      if (if_gnt_o || !if_req_i)
         w_starve_nxt = 3'd0;
      else if (dm_gnt_o && (r_starve_cnt != c_starve_max))
         w_starve_nxt = r_starve_cnt + 3'd1;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: cycle-by-cycle vector table plus a latency sequence.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        if_req_i = 1'b0, if_kill_i = 1'b0;
   logic [31:0] if_addr_i = 32'd0;
   logic        dm_req_i = 1'b0, dm_we_i = 1'b0;
   logic [31:0] dm_addr_i = 32'd0, dm_wdata_i = 32'd0;
   logic [31:0] mem_rdata_i = 32'd0;
   logic        if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_en_o, mem_we_o;
   logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;

   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
      .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
      .dm_rdata_o(dm_rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   typedef struct {
      logic        rst, ifr, ifk, dmr, dmw;
      logic [31:0] ifa, dma, dmd;
      logic        ig, iv, dg, dv, en, we;
      logic [31:0] ma, md;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, ifr, input logic [31:0] ifa, input logic ifk,
                      input logic dmr, dmw, input logic [31:0] dma, dmd,
                      input logic ig, iv, dg, dv, en, we,
                      input logic [31:0] ma, md);
      vec_t v;
      v.rst = rst; v.ifr = ifr; v.ifa = ifa; v.ifk = ifk;
      v.dmr = dmr; v.dmw = dmw; v.dma = dma; v.dmd = dmd;
      v.ig = ig; v.iv = iv; v.dg = dg; v.dv = dv; v.en = en; v.we = we;
      v.ma = ma; v.md = md;
      vecs.push_back(v);
   endtask

   // Quiet cycle: no requests, no expected activity
   task automatic add_idle(input logic iv, dv);
      add(0, 0, 0, 0, 0, 0, 0, 0,  0, iv, 0, dv, 0, 0, 0, 0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   initial begin
      int lat;
      //   rst ifr ifa        ifk dmr dmw dma        dmd     ig iv dg dv en we ma         md
      add(1, 1, 32'h10,    0,  1,  0, 32'h20,    32'h0,   0, 0, 0, 0, 0, 0, 32'h0,     32'h0);
      add(1, 0, 32'h0,     0,  0,  0, 32'h0,     32'h0,   0, 0, 0, 0, 0, 0, 32'h0,     32'h0);
      // single fetch, rvalid two cycles after grant
      add(0, 1, 32'h40,    0,  0,  0, 32'h0,     32'h0,   1, 0, 0, 0, 1, 0, 32'h40,    32'h0);
      add_idle(0, 0);
      add_idle(1, 0);
      add_idle(0, 0);
      // contention: data first, fetch in the return cycle
      add(0, 1, 32'h80,    0,  1,  0, 32'h100,   32'h11,  0, 0, 1, 0, 1, 0, 32'h100,   32'h11);
      add(0, 1, 32'h80,    0,  0,  0, 32'h0,     32'h0,   0, 0, 0, 0, 0, 0, 32'h0,     32'h0);
      add(0, 1, 32'h80,    0,  0,  0, 32'h0,     32'h0,   1, 0, 0, 1, 1, 0, 32'h80,    32'h0);
      add_idle(0, 0);
      add_idle(1, 0);
      // starvation: three data writes then the fetch wins
      add(0, 1, 32'h200,   0,  1,  1, 32'h300,   32'hA1,  0, 0, 1, 0, 1, 1, 32'h300,   32'hA1);
      add(0, 1, 32'h200,   0,  1,  1, 32'h300,   32'hA2,  0, 0, 1, 0, 1, 1, 32'h300,   32'hA2);
      add(0, 1, 32'h200,   0,  1,  1, 32'h300,   32'hA3,  0, 0, 1, 0, 1, 1, 32'h300,   32'hA3);
      add(0, 1, 32'h200,   0,  1,  1, 32'h300,   32'hA4,  1, 0, 0, 0, 1, 0, 32'h200,   32'h0);
      add(0, 0, 32'h0,     0,  1,  1, 32'h300,   32'hA4,  0, 0, 0, 0, 0, 0, 32'h0,     32'h0);
      add(0, 0, 32'h0,     0,  1,  1, 32'h300,   32'hA4,  0, 1, 1, 0, 1, 1, 32'h300,   32'hA4);
      add_idle(0, 0);
      // kill while busy, data read granted in the return cycle
      add(0, 1, 32'h400,   0,  0,  0, 32'h0,     32'h0,   1, 0, 0, 0, 1, 0, 32'h400,   32'h0);
      add(0, 0, 32'h0,     1,  1,  0, 32'h500,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,     32'h0);
      add(0, 0, 32'h0,     0,  1,  0, 32'h500,   32'h0,   0, 0, 1, 0, 1, 0, 32'h500,   32'h0);
      add_idle(0, 0);
      add_idle(0, 1);
      // kill in the return cycle: no rvalid and no fetch grant that cycle
      add(0, 1, 32'h600,   0,  0,  0, 32'h0,     32'h0,   1, 0, 0, 0, 1, 0, 32'h600,   32'h0);
      add_idle(0, 0);
      add(0, 1, 32'h604,   1,  0,  0, 32'h0,     32'h0,   0, 0, 0, 0, 0, 0, 32'h0,     32'h0);
      add(0, 1, 32'h604,   0,  0,  0, 32'h0,     32'h0,   1, 0, 0, 0, 1, 0, 32'h604,   32'h0);
      add_idle(0, 0);
      add_idle(1, 0);
      // reset mid-read discards the data read
      add(0, 0, 32'h0,     0,  1,  0, 32'h700,   32'h0,   0, 0, 1, 0, 1, 0, 32'h700,   32'h0);
      add(1, 0, 32'h0,     0,  0,  0, 32'h0,     32'h0,   0, 0, 0, 0, 0, 0, 32'h0,     32'h0);
      add(0, 1, 32'h800,   0,  0,  0, 32'h0,     32'h0,   1, 0, 0, 0, 1, 0, 32'h800,   32'h0);
      add_idle(0, 0);
      add_idle(1, 0);
      // write-only stream never leaves idle
      for (int k = 0; k < 4; k++)
         add(0, 0, 32'h0, 0, 1, 1, 32'h900 + 32'(4*k), 32'(k + 1),
             0, 0, 1, 0, 1, 1, 32'h900 + 32'(4*k), 32'(k + 1));
      add(0, 1, 32'hA00,   0,  0,  0, 32'h0,     32'h0,   1, 0, 0, 0, 1, 0, 32'hA00,   32'h0);
      add_idle(0, 0);
      add_idle(1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_i);
         rst_i = vecs[i].rst; if_req_i = vecs[i].ifr; if_addr_i = vecs[i].ifa;
         if_kill_i = vecs[i].ifk; dm_req_i = vecs[i].dmr; dm_we_i = vecs[i].dmw;
         dm_addr_i = vecs[i].dma; dm_wdata_i = vecs[i].dmd;
         mem_rdata_i = 32'hC0DE_0000 + 32'(i);
         #1;
         chk($sformatf("row%0d if_gnt", i),    32'(if_gnt_o),    32'(vecs[i].ig));
         chk($sformatf("row%0d if_rvalid", i), 32'(if_rvalid_o), 32'(vecs[i].iv));
         chk($sformatf("row%0d dm_gnt", i),    32'(dm_gnt_o),    32'(vecs[i].dg));
         chk($sformatf("row%0d dm_rvalid", i), 32'(dm_rvalid_o), 32'(vecs[i].dv));
         chk($sformatf("row%0d mem_en", i),    32'(mem_en_o),    32'(vecs[i].en));
         chk($sformatf("row%0d mem_we", i),    32'(mem_we_o),    32'(vecs[i].we));
         chk($sformatf("row%0d mem_addr", i),  mem_addr_o,       vecs[i].ma);
         chk($sformatf("row%0d mem_wdata", i), mem_wdata_o,      vecs[i].md);
         chk($sformatf("row%0d if_rdata", i),  if_rdata_o,       32'hC0DE_0000 + 32'(i));
         chk($sformatf("row%0d dm_rdata", i),  dm_rdata_o,       32'hC0DE_0000 + 32'(i));
      end

      // Data read, then count cycles until its rvalid with a bounded wait
      @(negedge clk_i);
      rst_i = 1'b0; if_req_i = 1'b0; if_kill_i = 1'b0;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'hB00; mem_rdata_i = 32'h5A5A_1234;
      #1;
      chk("seq dm_gnt", 32'(dm_gnt_o), 32'd1);
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_i);
         dm_req_i = 1'b0;
         #1;
         if (dm_rvalid_o) begin
            lat = k;
            break;
         end
      end
      chk("seq dm latency", 32'(lat), 32'd2);
      chk("seq dm_rdata", dm_rdata_o, 32'h5A5A_1234);
      chk("seq no if_rvalid", 32'(if_rvalid_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
